// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction width, opcodes and the branch offset helper.
// Latency: none (package only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int          INSN_W  = 32;
    localparam logic [5:0]  OPC_B   = 6'b000101;
    localparam logic [10:0] OPC_ADD = 11'b10001011000;

    // Sign-extend a 26-bit branch immediate and keep only the low 'width' bits,
    // so adding it to a width-bit PC gives modulo-2^width arithmetic.
    function automatic logic [63:0] sext26_to_pc(input logic [25:0] imm26, input int width);
        logic [63:0] ext;
        logic [63:0] mask;
        ext  = {{38{imm26[25]}}, imm26};
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return ext & mask;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for a fetched {insn, pc} that decode could not take.
// Latency: captured entry is visible the cycle after fill.
// Backpressure: holds its entry until drain; flush discards it unconditionally.
module fetch_skid #(
    parameter int PC_W = 30
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            fill,
    input  logic            drain,
    input  logic            flush,
    input  logic [31:0]     in_insn,
    input  logic [PC_W-1:0] in_pc,
    output logic            valid,
    output logic [31:0]     insn,
    output logic [PC_W-1:0] pc
);

    // Occupancy flag: flush beats fill, fill beats drain.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // Payload capture; cleared on reset so the unused mux leg never carries X.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            insn <= '0;
            pc   <= '0;
        end else if (fill) begin
            insn <= in_insn;
            pc   <= in_pc;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: PC sequencing, in-fetch B resolution, redirects, skid to decode.
// Latency: word on imem_rdata/out one cycle after issue; B costs one bubble, redirect two cycles.
// Backpressure: out_ready low parks the in-flight word in a 1-entry skid and stops issuing.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 30,
    parameter int              IMEM_AW  = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               resetn,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_insn,
    output logic [PC_W-1:0]    out_pc,
    output logic               out_taken,
    output logic [7:0]         dbg_pc
);

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] req_pc;
    logic            req_valid;

    logic            skid_valid;
    logic [31:0]     skid_insn;
    logic [PC_W-1:0] skid_pc;

    logic            accept;
    logic            is_b;
    logic            b_accept;
    logic            flush;
    logic            issue;
    logic            skid_fill;
    logic            skid_drain;
    logic [PC_W-1:0] b_off;
    logic [PC_W-1:0] b_target;

    // The skid entry, when present, is always older than anything in flight.
    assign out_insn  = skid_valid ? skid_insn : imem_rdata;
    assign out_pc    = skid_valid ? skid_pc   : req_pc;

    // A redirect kills whatever is on the output this cycle; reset silences it too.
    assign out_valid = resetn & (skid_valid | req_valid) & ~redirect_valid;
    assign accept    = out_valid & out_ready;

    assign is_b      = (out_insn[31:26] == OPC_B);
    assign out_taken = out_valid & is_b;
    assign b_accept  = accept & is_b;
    assign flush     = redirect_valid | b_accept;

    // Issue only when the word it produces next cycle is guaranteed a home.
    assign issue     = resetn & ~flush & (skid_valid ? out_ready : (~req_valid | out_ready));
    assign skid_fill  = req_valid & ~out_ready & ~skid_valid & ~flush;
    assign skid_drain = skid_valid & out_ready;

    // Branch target is plain modular addition; imm=0 loops on itself.
    assign b_off     = PC_W'(sext26_to_pc(out_insn[25:0], PC_W));
    assign b_target  = out_pc + b_off;

    assign imem_en   = issue;
    assign imem_addr = fetch_pc[IMEM_AW-1:0];

    if (PC_W >= 8) begin : g_dbg_wide
        assign dbg_pc = fetch_pc[7:0];
    end else begin : g_dbg_narrow
        assign dbg_pc = {{(8-PC_W){1'b0}}, fetch_pc};
    end

    // PC sequencing and in-flight request tracking; redirect > B accept > issue.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc  <= RESET_PC;
            req_pc    <= RESET_PC;
            req_valid <= 1'b0;
        end else begin
            // No issue also covers "word consumed" and "word moved into the skid".
            req_valid <= issue;
            if (issue) begin
                req_pc <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (b_accept) begin
                fetch_pc <= b_target;
            end else if (issue) begin
                fetch_pc <= fetch_pc + PC_W'(1);
            end
        end
    end

    fetch_skid #(
        .PC_W (PC_W)
    ) u_skid (
        .clk     (clk),
        .resetn  (resetn),
        .fill    (skid_fill),
        .drain   (skid_drain),
        .flush   (flush),
        .in_insn (imem_rdata),
        .in_pc   (req_pc),
        .valid   (skid_valid),
        .insn    (skid_insn),
        .pc      (skid_pc)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential flow, B resolution, backpressure, redirect, reset/wrap.
// Latency: checks are cycle-exact against hand-built tables.
// Backpressure: out_ready is driven from the tables.
module tb_pc_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Default-parameter instance
    logic        resetn = 1'b0;
    logic        imem_en;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [29:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_insn;
    logic [29:0] out_pc;
    logic        out_taken;
    logic [7:0]  dbg_pc;
    logic [31:0] mem_a [0:511];

    // Narrow instance for reset-PC and wrap behaviour
    logic        resetn_b = 1'b0;
    logic        imem_en_b;
    logic [3:0]  imem_addr_b;
    logic [31:0] imem_rdata_b = '0;
    logic        redirect_valid_b = 1'b0;
    logic [3:0]  redirect_pc_b = '0;
    logic        out_valid_b;
    logic        out_ready_b = 1'b1;
    logic [31:0] out_insn_b;
    logic [3:0]  out_pc_b;
    logic        out_taken_b;
    logic [7:0]  dbg_pc_b;
    logic [31:0] mem_b [0:15];

    always #5 clk = ~clk;

    pc_fetch_unit dut_a (
        .clk(clk), .resetn(resetn), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_pc(out_pc),
        .out_taken(out_taken), .dbg_pc(dbg_pc)
    );

    pc_fetch_unit #(.PC_W(4), .IMEM_AW(4), .RESET_PC(4'd14)) dut_b (
        .clk(clk), .resetn(resetn_b), .imem_en(imem_en_b), .imem_addr(imem_addr_b),
        .imem_rdata(imem_rdata_b), .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_insn(out_insn_b), .out_pc(out_pc_b),
        .out_taken(out_taken_b), .dbg_pc(dbg_pc_b)
    );

    // Synchronous 1-cycle-latency instruction memories
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_a[imem_addr];
        if (imem_en_b) imem_rdata_b <= mem_b[imem_addr_b];
    end

    function automatic logic [31:0] add_insn(input int k);
        return {OPC_ADD, 21'(k)};
    endfunction

    function automatic logic [31:0] b_insn(input logic [25:0] imm);
        return {OPC_B, imm};
    endfunction

    task automatic load_mem();
        for (int i = 0; i < 512; i++) mem_a[i] = add_insn(i);
        for (int i = 0; i < 16; i++) mem_b[i] = add_insn(i + 100);
    endtask

    // Advance one cycle and check the skid/in-flight exclusivity on both instances.
    task automatic next();
        @(posedge clk);
        #1;
        n_checks++;
        if ((dut_a.skid_valid & dut_a.req_valid) !== 1'b0 || (dut_b.skid_valid & dut_b.req_valid) !== 1'b0) begin
            n_fail++;
            $display("FAIL invariant: skid&req a=%b b=%b, want 0", dut_a.skid_valid & dut_a.req_valid,
                     dut_b.skid_valid & dut_b.req_valid);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        next();
        next();
    endtask

    task automatic test_reset();
        load_mem();
        do_reset();
        #1;
        n_checks++;
        if ({imem_en, out_valid, out_taken, dbg_pc} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_a: en=%b v=%b tk=%b dbg=%h, want all 0", imem_en, out_valid, out_taken, dbg_pc);
        end
        n_checks++;
        if ({imem_en_b, out_valid_b, out_taken_b, dbg_pc_b} !== {3'b000, 8'd14}) begin
            n_fail++;
            $display("FAIL reset_b: en=%b v=%b tk=%b dbg=%0d, want 0 0 0 14", imem_en_b, out_valid_b, out_taken_b, dbg_pc_b);
        end
    endtask

    task automatic test_sequential();
        load_mem();
        do_reset();
        resetn = 1'b1;
        #1;
        n_checks++;
        if ({imem_en, imem_addr, out_valid} !== {1'b1, 9'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL seq_first_issue: en=%b addr=%0d v=%b, want 1 0 0", imem_en, imem_addr, out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            next();
            n_checks++;
            if ({out_valid, out_pc, out_insn, out_taken, imem_en, imem_addr} !==
                {1'b1, 30'(i), mem_a[i], 1'b0, 1'b1, 9'(i + 1)}) begin
                n_fail++;
                $display("FAIL seq cycle %0d: v=%b pc=%0d insn=%h tk=%b en=%b addr=%0d, want pc=%0d addr=%0d",
                         i + 1, out_valid, out_pc, out_insn, out_taken, imem_en, imem_addr, i, i + 1);
            end
        end
    endtask

    // Shared runner shape for the branch tables: exp_pc<0 means a bubble.
    task automatic test_b_forward();
        int   exp_pc [5] = '{0, 1, -1, 4, 5};
        logic exp_tk [5] = '{0, 1, 0, 0, 0};
        logic exp_en [5] = '{1, 0, 1, 1, 1};
        logic ok;
        load_mem();
        mem_a[1] = b_insn(26'd3);
        do_reset();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next();
            if (exp_pc[i] < 0) ok = (out_valid === 1'b0);
            else ok = ({out_valid, out_pc, out_insn, out_taken} === {1'b1, 30'(exp_pc[i]), mem_a[exp_pc[i]], exp_tk[i]});
            ok = ok && (imem_en === exp_en[i]);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL b_forward cycle %0d: v=%b pc=%0d tk=%b en=%b, want pc=%0d tk=%b en=%b",
                         i + 1, out_valid, out_pc, out_taken, imem_en, exp_pc[i], exp_tk[i], exp_en[i]);
            end
        end
    endtask

    task automatic test_b_backward();
        int   exp_pc [10] = '{0, 1, 2, 3, 4, 5, 6, 7, -1, 4};
        logic exp_tk [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        logic exp_en [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        logic ok;
        load_mem();
        mem_a[7] = b_insn(26'h3FFFFFD);
        do_reset();
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            next();
            if (exp_pc[i] < 0) ok = (out_valid === 1'b0);
            else ok = ({out_valid, out_pc, out_insn, out_taken} === {1'b1, 30'(exp_pc[i]), mem_a[exp_pc[i]], exp_tk[i]});
            ok = ok && (imem_en === exp_en[i]);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL b_backward cycle %0d: v=%b pc=%0d tk=%b en=%b, want pc=%0d tk=%b en=%b",
                         i + 1, out_valid, out_pc, out_taken, imem_en, exp_pc[i], exp_tk[i], exp_en[i]);
            end
        end
    endtask

    task automatic test_self_loop();
        int   exp_pc [5] = '{10, -1, 10, -1, 10};
        logic exp_tk [5] = '{1, 0, 1, 0, 1};
        logic exp_en [5] = '{0, 1, 0, 1, 0};
        logic ok;
        load_mem();
        mem_a[10] = b_insn(26'd0);
        do_reset();
        resetn = 1'b1; redirect_valid = 1'b1; redirect_pc = 30'd10;
        #1;
        n_checks++;
        if ({out_valid, imem_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL loop_redirect_cycle: v=%b en=%b, want 0 0", out_valid, imem_en);
        end
        next();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, imem_en, imem_addr} !== {1'b0, 1'b1, 9'd10}) begin
            n_fail++;
            $display("FAIL loop_target_issue: v=%b en=%b addr=%0d, want 0 1 10", out_valid, imem_en, imem_addr);
        end
        for (int i = 0; i < 5; i++) begin
            next();
            if (exp_pc[i] < 0) ok = (out_valid === 1'b0);
            else ok = ({out_valid, out_pc, out_insn, out_taken} === {1'b1, 30'(exp_pc[i]), mem_a[exp_pc[i]], exp_tk[i]});
            ok = ok && (imem_en === exp_en[i]);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL self_loop cycle %0d: v=%b pc=%0d tk=%b en=%b, want pc=%0d tk=%b en=%b",
                         i + 2, out_valid, out_pc, out_taken, imem_en, exp_pc[i], exp_tk[i], exp_en[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic rdy    [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        int   exp_pc [8] = '{0, 1, 2, 2, 2, 2, 3, 4};
        logic exp_en [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        load_mem();
        do_reset();
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            next();
            out_ready = rdy[i];
            #1;
            n_checks++;
            if ({out_valid, out_pc, out_insn, imem_en} !== {1'b1, 30'(exp_pc[i]), mem_a[exp_pc[i]], exp_en[i]}) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d: v=%b pc=%0d insn=%h en=%b, want pc=%0d en=%b",
                         i + 1, out_valid, out_pc, out_insn, imem_en, exp_pc[i], exp_en[i]);
            end
        end
    endtask

    task automatic test_redirect_skid();
        logic rdy    [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        logic rv     [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        int   exp_pc [8] = '{0, 1, 2, 2, -1, -1, 16, 17};
        logic exp_en [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        logic ok;
        load_mem();
        do_reset();
        resetn = 1'b1;
        redirect_pc = 30'h10;
        for (int i = 0; i < 8; i++) begin
            next();
            out_ready = rdy[i];
            redirect_valid = rv[i];
            #1;
            if (exp_pc[i] < 0) ok = (out_valid === 1'b0);
            else ok = ({out_valid, out_pc, out_insn} === {1'b1, 30'(exp_pc[i]), mem_a[exp_pc[i]]});
            ok = ok && (imem_en === exp_en[i]);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL redirect_skid cycle %0d: v=%b pc=%0d en=%b, want pc=%0d en=%b",
                         i + 1, out_valid, out_pc, imem_en, exp_pc[i], exp_en[i]);
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_wrap();
        logic rstn   [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
        logic rdy    [9] = '{1, 0, 0, 1, 1, 1, 1, 1, 1};
        int   exp_pc [9] = '{14, 15, 15, -1, -1, 14, 15, 0, 1};
        logic exp_en [9] = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
        int   exp_f  [9] = '{15, 0, 0, 0, 14, 15, 0, 1, 2};
        logic ok;
        load_mem();
        resetn_b = 1'b0; out_ready_b = 1'b1;
        next();
        resetn_b = 1'b1;
        #1;
        n_checks++;
        if ({imem_en_b, imem_addr_b, out_valid_b} !== {1'b1, 4'd14, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_first_issue: en=%b addr=%0d v=%b, want 1 14 0", imem_en_b, imem_addr_b, out_valid_b);
        end
        for (int i = 0; i < 9; i++) begin
            next();
            resetn_b = rstn[i];
            out_ready_b = rdy[i];
            #1;
            if (exp_pc[i] < 0) ok = ({out_valid_b, out_taken_b} === 2'b00);
            else ok = ({out_valid_b, out_pc_b, out_insn_b} === {1'b1, 4'(exp_pc[i]), mem_b[exp_pc[i]]});
            ok = ok && (imem_en_b === exp_en[i]) && (imem_addr_b === 4'(exp_f[i])) && (dbg_pc_b === 8'(exp_f[i]));
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL reset_wrap cycle %0d: v=%b pc=%0d en=%b addr=%0d dbg=%0d, want pc=%0d en=%b fetch=%0d",
                         i + 1, out_valid_b, out_pc_b, imem_en_b, imem_addr_b, dbg_pc_b, exp_pc[i], exp_en[i], exp_f[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_b_forward();
        test_b_backward();
        test_self_loop();
        test_backpressure();
        test_redirect_skid();
        test_reset_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
